// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
//
// Shares one physical-memory port between an instruction cache (read-only line
// fills) and a data cache (line fills and writebacks). One transaction is in
// flight at a time. Under contention the two requesters strictly alternate, so
// a pending requester never waits longer than one foreign transaction.
//
// The memory-side command, address and write data all come from registers that
// are loaded at grant time. The memory completion pulse and read data are
// passed straight back to the caches in the same cycle.
//
// Ports
//   clk             sole clock, all state updates on the rising edge
//   rst_n           asynchronous active-low reset
//   i_pmem_read     I-cache line-fill request (held until i_pmem_resp)
//   i_pmem_address  I-cache line address
//   i_pmem_resp     I-cache completion pulse
//   i_pmem_rdata    I-cache fill data (mirror of pmem_rdata)
//   d_pmem_read     D-cache line-fill request (held until d_pmem_resp)
//   d_pmem_write    D-cache writeback request (held until d_pmem_resp)
//   d_pmem_address  D-cache line address
//   d_pmem_wdata    D-cache writeback data
//   d_pmem_resp     D-cache completion pulse
//   d_pmem_rdata    D-cache fill data (mirror of pmem_rdata)
//   pmem_read       memory read command (registered)
//   pmem_write      memory write command (registered)
//   pmem_address    memory address (registered)
//   pmem_wdata      memory write data (registered)
//   pmem_resp       memory completion, one cycle per transaction
//   pmem_rdata      memory read data, valid with pmem_resp
// -----------------------------------------------------------------------------
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic              i_pmem_resp,
  output logic [LINE_W-1:0] i_pmem_rdata,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [LINE_W-1:0] d_pmem_rdata,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0]        state_reg, state_next;
  logic              last_grant_reg, last_grant_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LINE_W-1:0] wdata_reg, wdata_next;
  logic              read_reg, read_next;
  logic              write_reg, write_next;

  logic              i_pending;
  logic              d_pending;
  logic              serving;
  logic              grant_i;
  logic              grant_d;

  // Index 0 is the I side, index 1 the D side.
  logic [1:0]        serve_vec;
  logic [1:0]        resp_vec;

  // A requester being served is never "pending": it is still holding its
  // request lines, and must not be regranted on its own completion cycle.
  assign i_pending = i_pmem_read && (state_reg != SERVE_I);
  assign d_pending = (d_pmem_read || d_pmem_write) && (state_reg != SERVE_D);
  assign serving   = (state_reg == SERVE_I) || (state_reg == SERVE_D);

  // Grant decision. From IDLE the tie-break favours whoever did not win last
  // time. On a completion cycle the other side is granted directly, which
  // removes the idle bubble and gives strict alternation under load.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_pending && d_pending) begin
          if (last_grant_reg == GRANT_I) begin
            grant_d = 1'b1;
          end else begin
            grant_i = 1'b1;
          end
        end else if (i_pending) begin
          grant_i = 1'b1;
        end else if (d_pending) begin
          grant_d = 1'b1;
        end
      end
      SERVE_I: begin
        if (pmem_resp && d_pending) begin
          grant_d = 1'b1;
        end
      end
      SERVE_D: begin
        if (pmem_resp && i_pending) begin
          grant_i = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    read_next       = read_reg;
    write_next      = write_reg;

    if (grant_i) begin
      state_next      = SERVE_I;
      last_grant_next = GRANT_I;
      addr_next       = i_pmem_address;
      read_next       = 1'b1;
      write_next      = 1'b0;
    end else if (grant_d) begin
      state_next      = SERVE_D;
      last_grant_next = GRANT_D;
      addr_next       = d_pmem_address;
      wdata_next      = d_pmem_wdata;
      // A writeback takes precedence if both D request lines are high.
      write_next      = d_pmem_write;
      read_next       = !d_pmem_write;
    end else if (serving && pmem_resp) begin
      state_next = IDLE;
      read_next  = 1'b0;
      write_next = 1'b0;
    end else if (!serving && (state_reg != IDLE)) begin
      // Unused encoding: fall back to IDLE with the command dropped.
      state_next = IDLE;
      read_next  = 1'b0;
      write_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_I;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      read_reg       <= 1'b0;
      write_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      read_reg       <= read_next;
      write_reg      <= write_next;
    end
  end

  assign pmem_read    = read_reg;
  assign pmem_write   = write_reg;
  assign pmem_address = addr_reg;
  assign pmem_wdata   = wdata_reg;

  // Completion routing: only the side currently being served sees the pulse,
  // so a stray pmem_resp while IDLE (e.g. after a reset) is dropped.
  assign serve_vec = {(state_reg == SERVE_D), (state_reg == SERVE_I)};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      assign resp_vec[gi] = pmem_resp && serve_vec[gi];
    end
  endgenerate

  assign i_pmem_resp = resp_vec[0];
  assign d_pmem_resp = resp_vec[1];

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pmem_arbiter
//
// Two requester drivers (I and D) consume directed request queues. The test
// sequence pushes, alongside the requests, the hand-computed order of memory
// transactions it expects. A memory model / monitor pops that queue whenever
// a new command appears on the shared port, checks it, responds after a fixed
// latency and checks the completion routing and data.
// -----------------------------------------------------------------------------
module tb_pmem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 256;
  localparam int MEM_LAT = 2;

  typedef struct {
    logic              is_d;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic              b2b;
  } exp_t;

  typedef struct {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic              drop;
  } req_t;

  logic              clk;
  logic              rst_n;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic              i_pmem_resp;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic              d_pmem_resp;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;

  exp_t exp_q[$];
  req_t i_q[$];
  req_t d_q[$];

  int checks = 0;
  int errors = 0;
  bit stray  = 1'b0;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_resp    (i_pmem_resp),
    .i_pmem_rdata   (i_pmem_rdata),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_resp    (d_pmem_resp),
    .d_pmem_rdata   (d_pmem_rdata),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_resp      (pmem_resp),
    .pmem_rdata     (pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [LINE_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
    if (a == 32'h0000_1000) return {32{8'hA5}};
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic push_i(input logic [ADDR_W-1:0] a, input logic drop);
    req_t r;
    r = '{1'b1, 1'b0, a, 256'h0, drop};
    i_q.push_back(r);
  endtask

  task automatic push_d(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [LINE_W-1:0] wd);
    req_t r;
    r = '{rd, wr, a, wd, 1'b0};
    d_q.push_back(r);
  endtask

  task automatic push_exp(input logic is_d, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [LINE_W-1:0] wd, input logic b2b);
    exp_t e;
    e = '{is_d, wr, a, wd, b2b};
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // I-side requester: holds its request until its resp (or a reset), then
  // immediately moves on to the next queued request in the same cycle.
  // ---------------------------------------------------------------------------
  initial begin : i_drv
    req_t r;
    int   cyc;
    bit   done;
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    forever begin
      if (i_q.size() == 0 || !rst_n) begin
        i_pmem_read = 1'b0;
        @(negedge clk); #2;
      end else begin
        r = i_q.pop_front();
        i_pmem_read    = 1'b1;
        i_pmem_address = r.addr;
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
          @(negedge clk); #2;
          cyc++;
          if (!rst_n) begin
            done = 1'b1;
          end else if (i_pmem_resp) begin
            $display("I  resp addr=0x%08h rdata=0x%0h", r.addr, i_pmem_rdata);
            done = 1'b1;
          end else if (cyc > 200) begin
            checks++;
            errors++;
            $display("FAIL i_resp_timeout: waited %0d cycles, required a resp", cyc);
            done = 1'b1;
          end
          if (r.drop && !done) i_pmem_read = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // D-side requester, same discipline as the I side.
  // ---------------------------------------------------------------------------
  initial begin : d_drv
    req_t r;
    int   cyc;
    bit   done;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    forever begin
      if (d_q.size() == 0 || !rst_n) begin
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        @(negedge clk); #2;
      end else begin
        r = d_q.pop_front();
        d_pmem_read    = r.rd;
        d_pmem_write   = r.wr;
        d_pmem_address = r.addr;
        d_pmem_wdata   = r.wdata;
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
          @(negedge clk); #2;
          cyc++;
          if (!rst_n) begin
            done = 1'b1;
          end else if (d_pmem_resp) begin
            $display("D  resp addr=0x%08h wr=%0b rdata=0x%0h", r.addr, r.wr, d_pmem_rdata);
            done = 1'b1;
          end else if (cyc > 200) begin
            checks++;
            errors++;
            $display("FAIL d_resp_timeout: waited %0d cycles, required a resp", cyc);
            done = 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory model and monitor.
  // ---------------------------------------------------------------------------
  initial begin : mem_mon
    exp_t cur;
    bit   cur_valid;
    bit   seen;
    bit   prev_resp;
    int   lat;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    cur_valid  = 1'b0;
    seen       = 1'b0;
    prev_resp  = 1'b0;
    lat        = 0;
    cur        = '{1'b0, 1'b0, 32'h0, 256'h0, 1'b0};
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (!rst_n) begin
        seen      = 1'b0;
        prev_resp = 1'b0;
        lat       = 0;
      end else if (stray) begin
        stray      = 1'b0;
        pmem_resp  = 1'b1;
        pmem_rdata = {LINE_W{1'b1}};
        #1;
        $display("MEM stray resp i_resp=%0b d_resp=%0b", i_pmem_resp, d_pmem_resp);
        chk("stray_i_resp", i_pmem_resp, 0);
        chk("stray_d_resp", d_pmem_resp, 0);
      end else begin
        if (prev_resp && exp_q.size() > 0 && exp_q[0].b2b)
          chk("no_idle_bubble", pmem_read | pmem_write, 1);
        prev_resp = 1'b0;
        if (pmem_read || pmem_write) begin
          if (!seen) begin
            seen = 1'b1;
            lat  = MEM_LAT;
            $display("MEM cmd rd=%0b wr=%0b addr=0x%08h", pmem_read, pmem_write, pmem_address);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              cur_valid = 1'b0;
              $display("FAIL unexpected_cmd: actual rd=%0b wr=%0b addr=0x%08h, required no command",
                       pmem_read, pmem_write, pmem_address);
            end else begin
              cur       = exp_q.pop_front();
              cur_valid = 1'b1;
              chk("cmd_write", pmem_write, cur.wr);
              chk("cmd_read", pmem_read, !cur.wr);
              chk("cmd_addr", pmem_address, cur.addr);
              if (cur.wr) chk("cmd_wdata", pmem_wdata, cur.wdata);
            end
          end
          if (lat == 0) begin
            pmem_resp  = 1'b1;
            pmem_rdata = mem_data(cur_valid ? cur.addr : pmem_address);
            seen       = 1'b0;
            prev_resp  = 1'b1;
            #1;
            if (cur_valid) begin
              chk("i_resp_route", i_pmem_resp, !cur.is_d);
              chk("d_resp_route", d_pmem_resp, cur.is_d);
              chk("i_rdata", i_pmem_rdata, mem_data(cur.addr));
              chk("d_rdata", d_pmem_rdata, mem_data(cur.addr));
            end
            cur_valid = 1'b0;
          end else begin
            lat--;
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pmem_read"}, pmem_read, 0);
    chk({tag, "_pmem_write"}, pmem_write, 0);
    chk({tag, "_pmem_address"}, pmem_address, 0);
    chk({tag, "_pmem_wdata"}, pmem_wdata, 0);
    chk({tag, "_i_resp"}, i_pmem_resp, 0);
    chk({tag, "_d_resp"}, d_pmem_resp, 0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk); #3;
      n++;
    end while (!(exp_q.size() == 0 && i_q.size() == 0 && d_q.size() == 0 &&
                 !i_pmem_read && !d_pmem_read && !d_pmem_write &&
                 !pmem_read && !pmem_write) && n < 1000);
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d expected transactions outstanding, required 0",
               tag, exp_q.size());
      exp_q.delete();
      i_q.delete();
      d_q.delete();
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs(tag);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed test sequence.
  // ---------------------------------------------------------------------------
  initial begin : main
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Single I fill, A5 data pattern.
    @(negedge clk); #3;
    push_i(32'h0000_1000, 1'b0);
    push_exp(1'b0, 1'b0, 32'h0000_1000, 256'h0, 1'b0);
    wait_done("t1");

    // Contention straight out of reset: D first, then I with no bubble.
    do_reset("rst2");
    push_i(32'h0000_1100, 1'b0);
    push_d(1'b1, 1'b0, 32'h0000_2100, 256'h0);
    push_exp(1'b1, 1'b0, 32'h0000_2100, 256'h0, 1'b0);
    push_exp(1'b0, 1'b0, 32'h0000_1100, 256'h0, 1'b1);
    wait_done("t2");

    // D writeback, then D fill, with I pending: I slots in between.
    @(negedge clk); #3;
    push_d(1'b0, 1'b1, 32'h0000_2000, {8{32'h1234_5678}});
    push_d(1'b1, 1'b0, 32'h0000_3000, 256'h0);
    push_i(32'h0000_4000, 1'b0);
    push_exp(1'b1, 1'b1, 32'h0000_2000, {8{32'h1234_5678}}, 1'b0);
    push_exp(1'b0, 1'b0, 32'h0000_4000, 256'h0, 1'b1);
    push_exp(1'b1, 1'b0, 32'h0000_3000, 256'h0, 1'b1);
    wait_done("t3");

    // Both D read and D write high: a single write transaction.
    @(negedge clk); #3;
    push_d(1'b1, 1'b1, 32'h0000_5000, {8{32'hDEAD_BEEF}});
    push_exp(1'b1, 1'b1, 32'h0000_5000, {8{32'hDEAD_BEEF}}, 1'b0);
    wait_done("t4");

    // I drops its request mid-transaction; command and resp must still occur.
    @(negedge clk); #3;
    push_i(32'h0000_6000, 1'b1);
    push_exp(1'b0, 1'b0, 32'h0000_6000, 256'h0, 1'b0);
    wait_done("t5");

    // Reset during a D fill, then a stray pmem_resp.
    @(negedge clk); #3;
    push_d(1'b1, 1'b0, 32'h0000_7000, 256'h0);
    push_exp(1'b1, 1'b0, 32'h0000_7000, 256'h0, 1'b0);
    n = 0;
    do begin
      @(negedge clk); #3;
      n++;
    end while (!pmem_read && n < 50);
    chk("t6_cmd_seen", pmem_read, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    $display("RST asserted mid-transaction pmem_read=%0b", pmem_read);
    check_reset_outputs("t6_async");
    @(negedge clk); #4;
    rst_n = 1'b1;
    @(negedge clk); #3;
    stray = 1'b1;
    @(negedge clk); #3;
    @(negedge clk); #3;
    chk("t6_idle_read", pmem_read, 0);
    chk("t6_idle_write", pmem_write, 0);
    wait_done("t6");

    // Continuous contention: D,I,D,I,... all back to back after the first.
    for (int k = 0; k < 4; k++) begin
      logic [ADDR_W-1:0] da;
      logic [ADDR_W-1:0] ia;
      logic [LINE_W-1:0] wd;
      logic              dw;
      da = 32'h0000_9000 + 32'(k * 64);
      ia = 32'h0000_8000 + 32'(k * 64);
      wd = {8{32'h5A00_0000 + 32'(k)}};
      dw = (k % 2) == 1;
      push_d(!dw, dw, da, wd);
      push_i(ia, 1'b0);
      push_exp(1'b1, dw, da, wd, k != 0);
      push_exp(1'b0, 1'b0, ia, 256'h0, 1'b1);
    end
    wait_done("t7");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
